// File: rtl/hazard_ctrl_if.sv
// Pipeline hazard interface: register indices and timing in, forward selects, stall and
// mult/div status out.
interface hazard_ctrl_if #(
    parameter int AW = 5,
    parameter int CW = 16
);
    logic [AW-1:0] rs_d, rt_d, rs_e, rt_e, rt_m;
    logic [AW-1:0] dst_e, dst_m, dst_w;
    logic [1:0]    tuse_rs_d, tuse_rt_d;
    logic [1:0]    tnew_e, tnew_m;
    logic          md_start_e, md_div_e, md_use_d;
    logic [1:0]    frs_d, frt_d, frs_e, frt_e;
    logic          frt_m;
    logic          stall, flush_e;
    logic          md_busy, md_err;
    logic [CW-1:0] stall_cnt;

    modport master (
        output rs_d, rt_d, rs_e, rt_e, rt_m, dst_e, dst_m, dst_w,
               tuse_rs_d, tuse_rt_d, tnew_e, tnew_m, md_start_e, md_div_e, md_use_d,
        input  frs_d, frt_d, frs_e, frt_e, frt_m, stall, flush_e, md_busy, md_err, stall_cnt
    );

    modport slave (
        input  rs_d, rt_d, rs_e, rt_e, rt_m, dst_e, dst_m, dst_w,
               tuse_rs_d, tuse_rt_d, tnew_e, tnew_m, md_start_e, md_div_e, md_use_d,
        output frs_d, frt_d, frs_e, frt_e, frt_m, stall, flush_e, md_busy, md_err, stall_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard unit for a 5-stage pipeline: operand forwarding, load-use and mult/div stalls,
// mult/div busy counter and a saturating stall counter.
module hazard_ctrl #(
    parameter int AW       = 5,
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10,
    parameter int CW       = 16
) (
    input logic         clk,
    input logic         reset,
    hazard_ctrl_if.slave hif
);
    localparam int MAXC = (DIV_CYC > MULT_CYC) ? DIV_CYC : MULT_CYC;
    localparam int MW   = $clog2(MAXC + 1);

    logic [MW-1:0] md_cnt;
    logic          md_err;
    logic [CW-1:0] stall_cnt;
    logic          data_stall, md_stall, stall;

    // Only M (with result ready) and W can feed a consumer; M wins over W.
    function automatic logic [1:0] fwd_sel(input logic [AW-1:0] src, input logic [AW-1:0] dm,
                                           input logic [AW-1:0] dw, input logic [1:0] tm);
        if (src != '0 && src == dm && tm == 2'd0)
            return 2'd1;
        else if (src != '0 && src == dw)
            return 2'd2;
        else
            return 2'd0;
    endfunction

    function automatic logic src_stall(input logic [AW-1:0] src, input logic [1:0] tuse,
                                       input logic [AW-1:0] de, input logic [1:0] te,
                                       input logic [AW-1:0] dm, input logic [1:0] tm);
        return (tuse != 2'd3) && (src != '0) &&
               ((src == de && tuse < te) || (src == dm && tuse < tm));
    endfunction

    assign hif.frs_d = fwd_sel(hif.rs_d, hif.dst_m, hif.dst_w, hif.tnew_m);
    assign hif.frt_d = fwd_sel(hif.rt_d, hif.dst_m, hif.dst_w, hif.tnew_m);
    assign hif.frs_e = fwd_sel(hif.rs_e, hif.dst_m, hif.dst_w, hif.tnew_m);
    assign hif.frt_e = fwd_sel(hif.rt_e, hif.dst_m, hif.dst_w, hif.tnew_m);
    assign hif.frt_m = (hif.rt_m != '0) && (hif.rt_m == hif.dst_w);

    assign data_stall = src_stall(hif.rs_d, hif.tuse_rs_d, hif.dst_e, hif.tnew_e, hif.dst_m, hif.tnew_m)
                      | src_stall(hif.rt_d, hif.tuse_rt_d, hif.dst_e, hif.tnew_e, hif.dst_m, hif.tnew_m);
    assign md_stall   = hif.md_use_d && ((md_cnt != '0) || hif.md_start_e);
    assign stall      = data_stall || md_stall;

    assign hif.stall     = stall;
    assign hif.flush_e   = stall;
    assign hif.md_busy   = (md_cnt != '0);
    assign hif.md_err    = md_err;
    assign hif.stall_cnt = stall_cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            md_cnt    <= '0;
            md_err    <= 1'b0;
            stall_cnt <= '0;
        end else begin
            if (stall && stall_cnt != '1)
                stall_cnt <= stall_cnt + CW'(1);
            // A start while busy is rejected outright: the counter holds that cycle.
            if (hif.md_start_e) begin
                if (md_cnt == '0)
                    md_cnt <= hif.md_div_e ? MW'(DIV_CYC) : MW'(MULT_CYC);
                else
                    md_err <= 1'b1;
            end else if (md_cnt != '0) begin
                md_cnt <= md_cnt - MW'(1);
            end
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized and directed bench for hazard_ctrl against a rule-level reference model.
module tb_hazard_ctrl;
    localparam int AW = 5;
    localparam int CW = 2;
    localparam int MULT_CYC = 5;
    localparam int DIV_CYC = 10;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_vec = 0;
    int   n_bad = 0;

    int m_rem = 0;
    int m_err = 0;
    int m_scnt = 0;

    hazard_ctrl_if #(.AW(AW), .CW(CW)) hif ();

    hazard_ctrl #(.AW(AW), .MULT_CYC(MULT_CYC), .DIV_CYC(DIV_CYC), .CW(CW)) dut (
        .clk  (clk),
        .reset(reset),
        .hif  (hif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int ref_fwd(input int src, input int dm, input int dw, input int tm);
        if (src == 0) return 0;
        if (src == dm && tm == 0) return 1;
        if (src == dw) return 2;
        return 0;
    endfunction

    function automatic int ref_src_stall(input int src, input int tuse);
        if (src == 0 || tuse == 3) return 0;
        if (src == int'(hif.dst_e) && tuse < int'(hif.tnew_e)) return 1;
        if (src == int'(hif.dst_m) && tuse < int'(hif.tnew_m)) return 1;
        return 0;
    endfunction

    function automatic int ref_stall();
        int ds, ms;
        ds = ref_src_stall(int'(hif.rs_d), int'(hif.tuse_rs_d)) |
             ref_src_stall(int'(hif.rt_d), int'(hif.tuse_rt_d));
        ms = (hif.md_use_d && (m_rem > 0 || hif.md_start_e)) ? 1 : 0;
        return ds | ms;
    endfunction

    task automatic idle();
        hif.rs_d = '0; hif.rt_d = '0; hif.rs_e = '0; hif.rt_e = '0; hif.rt_m = '0;
        hif.dst_e = '0; hif.dst_m = '0; hif.dst_w = '0;
        hif.tuse_rs_d = 2'd3; hif.tuse_rt_d = 2'd3; hif.tnew_e = '0; hif.tnew_m = '0;
        hif.md_start_e = 1'b0; hif.md_div_e = 1'b0; hif.md_use_d = 1'b0;
    endtask

    // Check the current cycle, then advance the model across the rising edge.
    task automatic step();
        int dm, dw, tm, st, smax;
        #1;
        dm = int'(hif.dst_m); dw = int'(hif.dst_w); tm = int'(hif.tnew_m);
        st = ref_stall();
        chk("frs_d", int'(hif.frs_d), ref_fwd(int'(hif.rs_d), dm, dw, tm));
        chk("frt_d", int'(hif.frt_d), ref_fwd(int'(hif.rt_d), dm, dw, tm));
        chk("frs_e", int'(hif.frs_e), ref_fwd(int'(hif.rs_e), dm, dw, tm));
        chk("frt_e", int'(hif.frt_e), ref_fwd(int'(hif.rt_e), dm, dw, tm));
        chk("frt_m", int'(hif.frt_m), (hif.rt_m != 0 && hif.rt_m == hif.dst_w) ? 1 : 0);
        chk("stall", int'(hif.stall), st);
        chk("flush_e", int'(hif.flush_e), st);
        chk("md_busy", int'(hif.md_busy), (m_rem > 0) ? 1 : 0);
        chk("md_err", int'(hif.md_err), m_err);
        chk("stall_cnt", int'(hif.stall_cnt), m_scnt);
        @(posedge clk);
        smax = (1 << CW) - 1;
        if (!reset) begin
            m_rem = 0; m_err = 0; m_scnt = 0;
        end else begin
            if (st != 0 && m_scnt < smax) m_scnt++;
            if (hif.md_start_e) begin
                if (m_rem == 0) m_rem = hif.md_div_e ? DIV_CYC : MULT_CYC;
                else m_err = 1;
            end else if (m_rem > 0) begin
                m_rem--;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        idle();
        @(negedge clk);
        step(); step();
        reset = 1'b1;

        // Load-use stall against E.
        hif.rs_d = 5'd5; hif.tuse_rs_d = 2'd0; hif.dst_e = 5'd5; hif.tnew_e = 2'd1;
        #1 chk("load_use_stall", int'(hif.stall), 1);
        step();
        idle();
        #1 chk("load_use_cnt", int'(hif.stall_cnt), 1);
        step();

        // Forward priority and register 0.
        hif.rs_e = 5'd7; hif.dst_m = 5'd7; hif.tnew_m = 2'd0; hif.dst_w = 5'd7;
        #1 chk("fwd_m_prio", int'(hif.frs_e), 1);
        step();
        hif.dst_m = 5'd0;
        #1 chk("fwd_w", int'(hif.frs_e), 2);
        step();
        hif.rt_d = 5'd0; hif.dst_w = 5'd0;
        #1 chk("fwd_r0", int'(hif.frt_d), 0);
        step();
        idle();
        // E result ready but never forwarded to D: no stall.
        hif.rs_d = 5'd9; hif.tuse_rs_d = 2'd0; hif.dst_e = 5'd9; hif.tnew_e = 2'd0;
        #1 chk("e_no_stall", int'(hif.stall), 0);
        step();
        idle();

        // Divide busy window with MD stall.
        hif.md_start_e = 1'b1; hif.md_div_e = 1'b1;
        step();
        idle();
        hif.md_use_d = 1'b1;
        for (int i = 0; i < DIV_CYC; i++) begin
            #1 chk("div_busy", int'(hif.md_busy), 1);
            chk("div_stall", int'(hif.stall), 1);
            step();
        end
        #1 chk("div_done", int'(hif.md_busy), 0);
        idle();
        step();

        // Overlapping start on the third busy cycle.
        hif.md_start_e = 1'b1;
        step();
        idle();
        step(); step();
        hif.md_start_e = 1'b1; hif.md_div_e = 1'b1;
        step();
        idle();
        #1 chk("md_err_set", int'(hif.md_err), 1);
        for (int i = 0; i < 8; i++) step();
        #1 chk("md_err_sticky", int'(hif.md_err), 1);

        // Reset during a divide.
        hif.md_start_e = 1'b1; hif.md_div_e = 1'b1;
        step();
        idle();
        step(); step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        #1 chk("rst_busy", int'(hif.md_busy), 0);
        chk("rst_err", int'(hif.md_err), 0);
        chk("rst_scnt", int'(hif.stall_cnt), 0);
        step();

        // Saturation with stall held.
        hif.md_use_d = 1'b1; hif.md_start_e = 1'b1;
        for (int i = 0; i < 6; i++) step();
        idle();
        #1 chk("scnt_sat", int'(hif.stall_cnt), 3);
        step();

        for (int i = 0; i < 3000; i++) begin
            hif.rs_d = AW'($urandom_range(0, 3)); hif.rt_d = AW'($urandom_range(0, 3));
            hif.rs_e = AW'($urandom_range(0, 3)); hif.rt_e = AW'($urandom_range(0, 3));
            hif.rt_m = AW'($urandom_range(0, 3));
            hif.dst_e = AW'($urandom_range(0, 3)); hif.dst_m = AW'($urandom_range(0, 3));
            hif.dst_w = AW'($urandom_range(0, 3));
            hif.tuse_rs_d = 2'($urandom_range(0, 3)); hif.tuse_rt_d = 2'($urandom_range(0, 3));
            hif.tnew_e = 2'($urandom_range(0, 3)); hif.tnew_m = 2'($urandom_range(0, 3));
            hif.md_start_e = ($urandom_range(0, 7) == 0);
            hif.md_div_e = 1'($urandom_range(0, 1));
            hif.md_use_d = ($urandom_range(0, 2) == 0);
            reset = ($urandom_range(0, 59) != 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter AW, default 5, register-index width.
REQ-002 Parameter MULT_CYC, default 5, multiply busy cycles (>=1).
REQ-003 Parameter DIV_CYC, default 10, divide busy cycles (>=1).
REQ-004 Parameter CW, default 16, stall-counter width.
REQ-005 Port clk  input  1  single clock; all state updates on rising edge.
REQ-006 Port reset  input  1  synchronous, active-low reset.
REQ-007 Ports rs_d, rt_d  input  AW each  D-stage source registers.
REQ-008 Ports tuse_rs_d, tuse_rt_d  input  2 each  stages until needed: 0 = D, 1 = E, 2 = M, 3 = unused.
REQ-009 Ports rs_e, rt_e  input  AW each  E-stage sources; rt_m  input  AW  M-stage store-data source.
REQ-010 Ports dst_e, dst_m, dst_w  input  AW each  destination register per stage; 0 means no write.
REQ-011 Ports tnew_e, tnew_m  input  2 each  cycles until that stage's result exists in its pipeline register.
REQ-012 Port md_start_e  input  1  mult/div issuing from E this cycle; md_div_e  input  1  1 = divide.
REQ-013 Port md_use_d  input  1  D-stage instruction touches HI/LO or the mult/div unit.
REQ-014 Ports frs_d, frt_d, frs_e, frt_e  output  2 each  forward select: 0 = own value, 1 = from M, 2 = from W.
REQ-015 Port frt_m  output  1  0 = own value, 1 = from W.
REQ-016 Port stall  output  1  freeze F/D, bubble E; flush_e  output  1  equal to stall.
REQ-017 Port md_busy  output  1  mult/div unit occupied.
REQ-018 Port md_err  output  1  sticky, md_start_e accepted while busy.
REQ-019 Port stall_cnt  output  CW  saturating count of stalled cycles.

Function
REQ-020 Forward selects and stall SHALL be combinational from current inputs and md state.
REQ-021 Register 0 SHALL never match; no forward or stall arises from dst or src equal to 0.
REQ-022 frs_d SHALL be 1 if rs_d==dst_m and tnew_m==0; else 2 if rs_d==dst_w; else 0. frt_d, frs_e, frt_e follow the same rule with their own source.
REQ-023 frt_m SHALL be 1 if rt_m==dst_w, else 0.
REQ-024 The M stage SHALL take priority over W when both match.
REQ-025 Data stall SHALL assert when, for rs_d or rt_d with tuse != 3: (src==dst_e and tuse < tnew_e) or (src==dst_m and tuse < tnew_m).
REQ-026 The E stage SHALL never forward into D; a D source matching dst_e with tnew_e==0 SHALL produce no stall and select per REQ-022.
REQ-027 MD stall SHALL assert when md_use_d and (md_busy or md_start_e).
REQ-028 stall SHALL be the OR of data stall and MD stall.
REQ-029 md counter: md_start_e with counter 0 SHALL load DIV_CYC if md_div_e, else MULT_CYC.
REQ-030 md counter SHALL otherwise decrement by 1 per cycle while nonzero.
REQ-031 md_busy SHALL equal (counter != 0), registered.
REQ-032 Busy length SHALL be exactly the loaded value in cycles, starting the cycle after md_start_e.
REQ-033 md_start_e while counter != 0 SHALL leave the counter unchanged and set md_err; md_err clears only on reset.
REQ-034 stall_cnt SHALL increment each cycle stall==1 and hold at 2^CW-1.

Reset
REQ-035 While reset==0 at a clock edge: md counter, md_busy, md_err and stall_cnt SHALL become 0.
REQ-036 Reset SHALL abort an in-flight mult/div; combinational outputs then follow inputs with md_busy=0.

Verification
REQ-037 rs_d=5, tuse_rs_d=0, dst_e=5, tnew_e=1 -> stall=1, flush_e=1, stall_cnt +1.
REQ-038 rs_e=7, dst_m=7, tnew_m=0, dst_w=7 -> frs_e=1; with dst_m=0 instead -> frs_e=2; rt_d=0, dst_m=0 -> frt_d=0.
REQ-039 md_start_e=1, md_div_e=1 for one cycle -> md_busy high exactly 10 cycles; md_use_d=1 during that window -> stall=1 each of those cycles.
REQ-040 Second md_start_e on 3rd busy cycle -> counter unchanged, md_err=1 and sticky.
REQ-041 reset=0 mid-divide -> next cycle md_busy=0, md_err=0, stall_cnt=0.
REQ-042 CW=2, stall held 6 cycles -> stall_cnt saturates at 3.
